salsa_stream_ctrl: RTL and testbench
====================================

SALSA_STREAM_CTRL -- requirements
Module: salsa_stream_ctrl

Interface
REQ-001 Parameter: NBLK_W, default 16, width of the block-count field.
REQ-002 CLK  in  1  single clock; all state updates on posedge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 CMD_VALID  in  1  command offered; CMD_READY  out  1  controller accepts a command.
REQ-005 CMD_KEY  in  256  key; CMD_NONCE  in  64  nonce; CMD_COUNTER  in  64  starting block counter.
REQ-006 CMD_NBLK  in  NBLK_W  number of 512-bit keystream blocks to apply.
REQ-007 PT_VALID  in  1; PT_READY  out  1; PT_DATA  in  128  plaintext word stream.
REQ-008 CT_VALID  out  1; CT_READY  in  1; CT_DATA  out  128  ciphertext word stream.
REQ-009 BUSY  out  1  command in progress; DONE  out  1  single-cycle completion pulse.

Function
REQ-010 Command accepted on CMD_VALID && CMD_READY; CMD_READY = 1 only in IDLE; key, nonce, counter and count registered at accept.
REQ-011 States: IDLE, LD_KEY, W_KEY, LD_CNT, W_CNT, GEN, W_GEN, XFER, ZERO, W_ZERO, FIN.
REQ-012 Each core strobe (SET_KEY, SET_COUNT, START_ENC) is asserted for exactly one cycle, only while core BUSY = 0; each W_* state exits when core BUSY samples 0.
REQ-013 Sequence: LD_KEY (SET_KEY, KEY_IN = key) -> W_KEY -> LD_CNT (SET_COUNT, DATA_IN = {counter, nonce}) -> W_CNT -> GEN.
REQ-014 Per block: four START_ENC pulses -- first generates the block (word 0 on core DATA_OUT), the next three shift out words 1, 2, 3; after the third shift the core is ready for a new block.
REQ-015 In XFER, PT_READY = !CT_VALID || CT_READY; on the PT handshake, CT_DATA <= PT_DATA ^ core DATA_OUT and CT_VALID <= 1.
REQ-016 CT_VALID clears on CT_READY unless a PT handshake occurs in the same cycle, in which case the register reloads with no bubble.
REQ-017 After a PT handshake: if more words remain, go to GEN; after word 3 of the last block, go to ZERO if REQ-026 applies, else FIN.
REQ-018 Word index is 2 bits and wraps 3 -> 0; the block counter decrements on each word-3 handshake.
REQ-019 CMD_NBLK = 0: no core strobe; DONE asserts in the cycle after accept.
REQ-020 Block counter in the core wraps modulo 2^64 and is not checked by the controller.
REQ-021 FIN: DONE = 1 for one cycle, then IDLE; DONE does not wait for CT drain, and a pending CT word persists until accepted.
REQ-022 BUSY = 1 in every state except IDLE.

Reset
REQ-023 RST clears the FSM to IDLE, clears all registered command fields and counters, and sets CT_VALID, DONE and strobes to 0; CMD_READY = 1 after release.
REQ-024 Core reset is driven as RST_N = ~RST; a reset mid-command aborts it with no DONE and discards any pending CT word.

Configuration
REQ-025 Macro SALSA_CTRL_ZEROIZE_EN selects key zeroization.
REQ-026 Defined: after the last word, ZERO issues SET_KEY with KEY_IN = 0 -> W_ZERO -> FIN; the controller's key register clears at the same time.
REQ-027 Undefined: the ZERO and W_ZERO states are absent and the key persists in the core until the next command.

Structure
REQ-028 Package salsa_ctrl_pkg holds the state enum, WORDS_PER_BLK = 4, and the default NBLK_W.
REQ-029 One sub-module: an instance of the existing Salsa20 core salsa (u_core), fully owned by this controller.

Verification
REQ-030 Key 0, nonce 0, counter 0, NBLK 1, PT = 0 -> four CT words equal the model keystream words 0..3 of the Salsa20 zero vector, then one DONE.
REQ-031 NBLK 3, counter 0xFFFF_FFFF_FFFF_FFFF, random PT -> 12 CT words; block 2 uses counter 1, matching the model after XOR.
REQ-032 CT_READY held 0 for 50 cycles mid-block -> PT_READY = 0 throughout, no word lost or duplicated, order preserved.
REQ-033 NBLK 0 -> no core strobes, DONE exactly one cycle after accept, CMD_READY high the following cycle.
REQ-034 RST pulsed during W_GEN of block 1 -> CT_VALID = 0 and BUSY = 0 immediately; a fresh command then produces correct output.
REQ-035 With SALSA_CTRL_ZEROIZE_EN defined -> SET_KEY with KEY_IN = 0 observed after the last PT handshake and before DONE.

Source files
------------

// File: rtl/salsa_ctrl_pkg.sv
// Shared types and constants for the Salsa20 stream controller.
// StZero/StWZero exist only when SALSA_CTRL_ZEROIZE_EN is defined.
package salsa_ctrl_pkg;

    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned NBLK_W_DEF    = 16;

    typedef enum logic [3:0] {
        StIdle,
        StLdKey,
        StWKey,
        StLdCnt,
        StWCnt,
        StGen,
        StWGen,
        StXfer,
`ifdef SALSA_CTRL_ZEROIZE_EN
        StZero,
        StWZero,
`endif
        StFin
    } state_e;

endpackage

// File: rtl/salsa.sv
// Iterative Salsa20/20 keystream core: one double round per cycle, 512-bit block
// presented as four 128-bit words, word 0 first, advanced by further start strobes.
module salsa (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_set_key,
    input  logic [255:0] i_key,
    input  logic         i_set_count,
    input  logic [127:0] i_data,
    input  logic         i_start,
    output logic [127:0] o_data,
    output logic         o_busy
);

    logic [255:0] r_key;
    logic [63:0]  r_nonce;
    logic [63:0]  r_ctr;
    logic [511:0] r_x;
    logic [511:0] r_out;
    logic [3:0]   r_rnd;
    logic [1:0]   r_phase;
    logic         r_busy;
    logic [511:0] w_init;
    logic [511:0] w_dr;
    logic [511:0] w_sum;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] ta, tb, tc, td;
        tb = b ^ rotl(a + d, 7);
        tc = c ^ rotl(tb + a, 9);
        td = d ^ rotl(tc + tb, 13);
        ta = a ^ rotl(td + tc, 18);
        return {ta, tb, tc, td};
    endfunction

    function automatic logic [511:0] dround(input logic [511:0] s);
        logic [31:0]  y [16];
        logic [511:0] res;
        for (int i = 0; i < 16; i++) y[i] = s[32*i +: 32];
        {y[0],  y[4],  y[8],  y[12]} = qr(y[0],  y[4],  y[8],  y[12]);
        {y[5],  y[9],  y[13], y[1]}  = qr(y[5],  y[9],  y[13], y[1]);
        {y[10], y[14], y[2],  y[6]}  = qr(y[10], y[14], y[2],  y[6]);
        {y[15], y[3],  y[7],  y[11]} = qr(y[15], y[3],  y[7],  y[11]);
        {y[0],  y[1],  y[2],  y[3]}  = qr(y[0],  y[1],  y[2],  y[3]);
        {y[5],  y[6],  y[7],  y[4]}  = qr(y[5],  y[6],  y[7],  y[4]);
        {y[10], y[11], y[8],  y[9]}  = qr(y[10], y[11], y[8],  y[9]);
        {y[15], y[12], y[13], y[14]} = qr(y[15], y[12], y[13], y[14]);
        for (int i = 0; i < 16; i++) res[32*i +: 32] = y[i];
        return res;
    endfunction

    // Input matrix: constants on the diagonal, key words 1..4 and 11..14.
    always_comb begin
        w_init            = '0;
        w_init[0   +: 32] = 32'h6170_7865;
        w_init[32  +:128] = r_key[127:0];
        w_init[160 +: 32] = 32'h3320_646e;
        w_init[192 +: 64] = r_nonce;
        w_init[256 +: 64] = r_ctr;
        w_init[320 +: 32] = 32'h7962_2d32;
        w_init[352 +:128] = r_key[255:128];
        w_init[480 +: 32] = 32'h6b20_6574;
        w_dr              = dround(r_x);
        for (int i = 0; i < 16; i++) w_sum[32*i +: 32] = w_dr[32*i +: 32] + w_init[32*i +: 32];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key   <= '0;
            r_nonce <= '0;
            r_ctr   <= '0;
            r_x     <= '0;
            r_out   <= '0;
            r_rnd   <= '0;
            r_phase <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (i_set_key) r_key <= i_key;
            if (i_set_count) {r_ctr, r_nonce} <= i_data;
            if (r_busy) begin
                r_x   <= w_dr;
                r_rnd <= r_rnd + 4'd1;
                if (r_rnd == 4'd9) begin
                    r_out   <= w_sum;
                    r_busy  <= 1'b0;
                    r_phase <= 2'd1;
                    r_ctr   <= r_ctr + 64'd1;
                    r_rnd   <= '0;
                end
            end else if (i_start) begin
                if (r_phase == 2'd0) begin
                    r_x    <= w_init;
                    r_busy <= 1'b1;
                end else begin
                    r_out   <= r_out >> 128;
                    r_phase <= r_phase + 2'd1;
                end
            end
        end
    end

    assign o_data = r_out[127:0];
    assign o_busy = r_busy;

endmodule

// File: rtl/salsa_stream_ctrl.sv
// Streams plaintext through a Salsa20 core, one 128-bit keystream word per PT beat.
// Define SALSA_CTRL_ZEROIZE_EN to wipe the core key after the last word.
module salsa_stream_ctrl
    import salsa_ctrl_pkg::*;
#(
    parameter int unsigned NBLK_W = NBLK_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [255:0]      i_cmd_key,
    input  logic [63:0]       i_cmd_nonce,
    input  logic [63:0]       i_cmd_counter,
    input  logic [NBLK_W-1:0] i_cmd_nblk,
    input  logic              i_pt_valid,
    output logic              o_pt_ready,
    input  logic [127:0]      i_pt_data,
    output logic              o_ct_valid,
    input  logic              i_ct_ready,
    output logic [127:0]      o_ct_data,
    output logic              o_busy,
    output logic              o_done
);

    state_e              r_state;
    logic [255:0]        r_key;
    logic [63:0]         r_nonce;
    logic [63:0]         r_ctr;
    logic [NBLK_W-1:0]   r_blk;
    logic [1:0]          r_word;
    logic                r_set_key;
    logic                r_set_count;
    logic                r_start_enc;
    logic                r_done;
    logic                r_ct_valid;
    logic [127:0]        r_ct_data;
    logic                w_core_busy;
    logic [127:0]        w_core_data;
    logic                w_pt_hs;
    logic                w_last_word;
    logic                w_last_blk;

    assign o_pt_ready  = (r_state == StXfer) && (!r_ct_valid || i_ct_ready);
    assign w_pt_hs     = o_pt_ready && i_pt_valid;
    assign w_last_word = (r_word == 2'(WORDS_PER_BLK - 1));
    assign w_last_blk  = (r_blk == NBLK_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_key       <= '0;
            r_nonce     <= '0;
            r_ctr       <= '0;
            r_blk       <= '0;
            r_word      <= '0;
            r_set_key   <= 1'b0;
            r_set_count <= 1'b0;
            r_start_enc <= 1'b0;
            r_done      <= 1'b0;
            r_ct_valid  <= 1'b0;
            r_ct_data   <= '0;
        end else begin
            r_set_key   <= 1'b0;
            r_set_count <= 1'b0;
            r_start_enc <= 1'b0;
            r_done      <= 1'b0;
            // A PT beat reloads the CT register even while the old word drains.
            if (w_pt_hs) begin
                r_ct_valid <= 1'b1;
                r_ct_data  <= i_pt_data ^ w_core_data;
            end else if (i_ct_ready) begin
                r_ct_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_key   <= i_cmd_key;
                        r_nonce <= i_cmd_nonce;
                        r_ctr   <= i_cmd_counter;
                        r_blk   <= i_cmd_nblk;
                        r_word  <= '0;
                        if (i_cmd_nblk == '0) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StLdKey;
                            r_set_key <= 1'b1;
                        end
                    end
                end
                StLdKey: r_state <= StWKey;
                StWKey: begin
                    if (!w_core_busy) begin
                        r_state     <= StLdCnt;
                        r_set_count <= 1'b1;
                    end
                end
                StLdCnt: r_state <= StWCnt;
                StWCnt: begin
                    if (!w_core_busy) begin
                        r_state     <= StGen;
                        r_start_enc <= 1'b1;
                    end
                end
                StGen: r_state <= StWGen;
                StWGen: begin
                    if (!w_core_busy) r_state <= StXfer;
                end
                StXfer: begin
                    if (w_pt_hs) begin
                        r_word <= r_word + 2'd1;
                        if (w_last_word) r_blk <= r_blk - NBLK_W'(1);
                        if (!w_last_word || !w_last_blk) begin
                            r_state     <= StGen;
                            r_start_enc <= 1'b1;
                        end else begin
`ifdef SALSA_CTRL_ZEROIZE_EN
                            r_state   <= StZero;
                            r_set_key <= 1'b1;
                            r_key     <= '0;
`else
                            r_state <= StFin;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SALSA_CTRL_ZEROIZE_EN
                StZero: r_state <= StWZero;
                StWZero: begin
                    if (!w_core_busy) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                    end
                end
`endif
                StFin: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    salsa u_core (
        .i_clk       (i_clk),
        .i_rst_n     (~i_rst),
        .i_set_key   (r_set_key),
        .i_key       (r_key),
        .i_set_count (r_set_count),
        .i_data      ({r_ctr, r_nonce}),
        .i_start     (r_start_enc),
        .o_data      (w_core_data),
        .o_busy      (w_core_busy)
    );

    assign o_cmd_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_ct_valid  = r_ct_valid;
    assign o_ct_data   = r_ct_data;

endmodule

// File: tb/tb_salsa_stream_ctrl.sv
// Directed bench for salsa_stream_ctrl against a reference Salsa20/20 block model.
module tb_salsa_stream_ctrl;
    import salsa_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [255:0] i_cmd_key;
    logic [63:0]  i_cmd_nonce;
    logic [63:0]  i_cmd_counter;
    logic [15:0]  i_cmd_nblk;
    logic         i_pt_valid;
    logic         o_pt_ready;
    logic [127:0] i_pt_data;
    logic         o_ct_valid;
    logic         i_ct_ready;
    logic [127:0] o_ct_data;
    logic         o_busy;
    logic         o_done;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;

    always #5 clk = ~clk;

    salsa_stream_ctrl #(.NBLK_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_key     (i_cmd_key),
        .i_cmd_nonce   (i_cmd_nonce),
        .i_cmd_counter (i_cmd_counter),
        .i_cmd_nblk    (i_cmd_nblk),
        .i_pt_valid    (i_pt_valid),
        .o_pt_ready    (o_pt_ready),
        .i_pt_data     (i_pt_data),
        .o_ct_valid    (o_ct_valid),
        .i_ct_ready    (i_ct_ready),
        .o_ct_data     (o_ct_data),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always @(negedge clk) begin
        if (dut.r_set_key || dut.r_set_count || dut.r_start_enc) n_strobe++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [511:0] salsa_ref(input logic [255:0] k, input logic [63:0] n,
                                               input logic [63:0] c);
        logic [31:0]  x [16];
        logic [31:0]  z [16];
        logic [511:0] res;
        int           qi [8][4];
        int           a, b, cc, d;
        qi = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
               '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};
        x[0]  = 32'h61707865;
        x[5]  = 32'h3320646e;
        x[10] = 32'h79622d32;
        x[15] = 32'h6b206574;
        for (int i = 0; i < 4; i++) begin
            x[1 + i]  = k[32*i +: 32];
            x[11 + i] = k[128 + 32*i +: 32];
        end
        x[6] = n[31:0];
        x[7] = n[63:32];
        x[8] = c[31:0];
        x[9] = c[63:32];
        z = x;
        for (int rr = 0; rr < 10; rr++) begin
            for (int q = 0; q < 8; q++) begin
                a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
                z[b]  ^= rol(z[a] + z[d], 7);
                z[cc] ^= rol(z[b] + z[a], 9);
                z[d]  ^= rol(z[cc] + z[b], 13);
                z[a]  ^= rol(z[d] + z[cc], 18);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = z[i] + x[i];
        return res;
    endfunction

    task automatic run_cmd(input string tag, input logic [255:0] key, input logic [63:0] nonce,
                           input logic [63:0] ctr, input int nblk, input bit zero_pt,
                           input int stall_at);
        logic [127:0] pt [$];
        logic [127:0] exp [$];
        logic [511:0] ks;
        logic [127:0] word;
        int total, sent, got, dones, tail, stall_left, bad_ready;
        bit stalled, last_hs, zero_seen;
        total = nblk * 4;
        sent = 0; got = 0; dones = 0; tail = 0; stall_left = 0; bad_ready = 0;
        stalled = 0; last_hs = 0; zero_seen = 0;
        for (int b = 0; b < nblk; b++) begin
            ks = salsa_ref(key, nonce, ctr + 64'(b));
            for (int w = 0; w < 4; w++) begin
                word = zero_pt ? '0 : {$urandom(), $urandom(), $urandom(), $urandom()};
                pt.push_back(word);
                exp.push_back(word ^ ks[128*w +: 128]);
            end
        end
        @(negedge clk);
        i_cmd_key = key;
        i_cmd_nonce = nonce;
        i_cmd_counter = ctr;
        i_cmd_nblk = 16'(nblk);
        i_cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 3000 && tail < 8; cyc++) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            if (o_done) dones++;
`ifdef SALSA_CTRL_ZEROIZE_EN
            if (last_hs && dones == 0 && dut.r_set_key && dut.r_key == '0) zero_seen = 1;
`endif
            if (stall_at >= 0 && !stalled && got == stall_at && o_ct_valid) begin
                stalled = 1;
                stall_left = 50;
            end
            i_ct_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            i_pt_valid = (sent < total);
            i_pt_data = (sent < total) ? pt[sent] : '0;
            #1;
            if (!i_ct_ready && o_pt_ready) bad_ready++;
            if (o_ct_valid && i_ct_ready) begin
                if (got < total) chk($sformatf("%s ct%0d", tag, got), o_ct_data, exp[got]);
                got++;
            end
            if (o_pt_ready && i_pt_valid) begin
                sent++;
                last_hs = (sent == total);
            end
            if (got >= total && dones > 0) tail++;
        end
        i_pt_valid = 1'b0;
        i_ct_ready = 1'b1;
        chk({tag, " words"}, 128'(got), 128'(total));
        chk({tag, " done_pulses"}, 128'(dones), 128'd1);
        if (stall_at >= 0) begin
            chk({tag, " stall_seen"}, 128'(stalled), 128'd1);
            chk({tag, " pt_ready_in_stall"}, 128'(bad_ready), 128'd0);
        end
`ifdef SALSA_CTRL_ZEROIZE_EN
        chk({tag, " zeroize"}, 128'(zero_seen), 128'd1);
`endif
    endtask

    initial begin
        bit hit;
        int s0;
        rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_key = '0;
        i_cmd_nonce = '0;
        i_cmd_counter = '0;
        i_cmd_nblk = '0;
        i_pt_valid = 1'b0;
        i_pt_data = '0;
        i_ct_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst cmd_ready", 128'(o_cmd_ready), 128'd1);
        chk("rst busy", 128'(o_busy), 128'd0);
        chk("rst ct_valid", 128'(o_ct_valid), 128'd0);
        chk("rst done", 128'(o_done), 128'd0);
        chk("rst pt_ready", 128'(o_pt_ready), 128'd0);
        chk("rst strobes", 128'(n_strobe), 128'd0);

        run_cmd("zero_vec", '0, '0, '0, 1, 1'b1, -1);
        run_cmd("ctr_wrap", {8{32'hA5C3_0F1E}}, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                3, 1'b0, -1);
        run_cmd("stall", {8{32'h1357_9BDF}}, 64'hCAFE_F00D_0000_0001, 64'd7, 2, 1'b0, 2);

        // Zero-block command: DONE in the cycle after accept, no core activity.
        s0 = n_strobe;
        @(negedge clk);
        i_cmd_nblk = '0;
        i_cmd_valid = 1'b1;
        #1 chk("nblk0 accept_ready", 128'(o_cmd_ready), 128'd1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk("nblk0 done", 128'(o_done), 128'd1);
        chk("nblk0 busy", 128'(o_busy), 128'd1);
        @(negedge clk);
        chk("nblk0 done_gone", 128'(o_done), 128'd0);
        chk("nblk0 cmd_ready", 128'(o_cmd_ready), 128'd1);
        chk("nblk0 strobes", 128'(n_strobe - s0), 128'd0);

        // Abort with a CT word pending, caught in W_GEN of the first block.
        @(negedge clk);
        i_cmd_key = {8{32'h0BAD_BEEF}};
        i_cmd_nblk = 16'd2;
        i_cmd_valid = 1'b1;
        i_ct_ready = 1'b0;
        i_pt_valid = 1'b1;
        i_pt_data = 128'h1234;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        hit = 0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            if (dut.r_state == StWGen && o_ct_valid) hit = 1;
        end
        chk("abort reach_wgen", 128'(hit), 128'd1);
        rst = 1'b1;
        #1;
        chk("abort ct_valid", 128'(o_ct_valid), 128'd0);
        chk("abort busy", 128'(o_busy), 128'd0);
        chk("abort done", 128'(o_done), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        i_pt_valid = 1'b0;
        i_ct_ready = 1'b1;
        @(negedge clk);
        chk("abort cmd_ready", 128'(o_cmd_ready), 128'd1);
        chk("abort no_done", 128'(o_done), 128'd0);
        run_cmd("fresh", {8{32'h0BAD_BEEF}}, 64'h55AA_55AA_0000_0003, 64'd100, 1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
